// File: rtl/dmem_pkg.sv
// Shared opcode constants, MMIO word offsets and lane/alignment helpers for
// the data-side memory responder.
package dmem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // MMIO register word offsets, i.e. addr[3:2] inside the window
    localparam logic [1:0] MMIO_CYCLE  = 2'd0;
    localparam logic [1:0] MMIO_STATUS = 2'd1;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [3:0] lane_sel(input logic [5:0] op, input logic [1:0] a);
        case (op)
            OP_SB:   lane_sel = 4'b0001 << a;
            OP_SH:   lane_sel = a[1] ? 4'b1100 : 4'b0011;
            OP_SW:   lane_sel = 4'b1111;
            default: lane_sel = 4'b0000;
        endcase
    endfunction

    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] a);
        case (op)
            OP_LH, OP_LHU, OP_SH: misaligned = a[0];
            OP_LW, OP_SW:         misaligned = (a != 2'b00);
            default:              misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// M-stage load/store bus between the CPU pipeline (master) and the data
// memory responder (slave).
interface data_mem_responder_if;
    logic [5:0]  opM;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] EXResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        DMemErr;
    logic [31:0] DMemErrAddr;

    modport master (
        output opM, MemReadM, MemWriteM, EXResultM, WriteDataM,
        input  ReadDataM, DMemErr, DMemErrAddr
    );

    modport slave (
        input  opM, MemReadM, MemWriteM, EXResultM, WriteDataM,
        output ReadDataM, DMemErr, DMemErrAddr
    );
endinterface

// File: rtl/dmem_load_align.sv
// Load formatter: picks the addressed byte/half/word out of a little-endian
// RAM word and sign- or zero-extends it according to the opcode.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [5:0]  i_op,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        case (i_op)
            OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_data = {24'b0, w_byte};
            OP_LH:   o_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_data = {16'b0, w_half};
            OP_LW:   o_data = i_word;
            default: o_data = 32'b0;
        endcase
    end
endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory responder: byte-lane RAM writes, same-cycle formatted
// loads, sticky misalignment fault. Define DMEM_MMIO_EN for the MMIO window.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);
    logic [31:0]       r_mem [0:(1<<ADDR_W)-1];
    logic              r_err;
    logic [31:0]       r_err_addr;
    logic [7:0]        r_fault_cnt;

    logic [ADDR_W-1:0] w_idx;
    logic [1:0]        w_lo;
    logic              w_ld_act, w_st_act, w_in_win, w_mis, w_fault, w_ram_we, w_stat_clr;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata, w_raw, w_aligned;

    assign w_lo     = bus.EXResultM[1:0];
    assign w_idx    = bus.EXResultM[ADDR_W+1:2];
    // A request with both strobes set behaves as a store and returns no data
    assign w_st_act = bus.MemWriteM & is_store(bus.opM);
    assign w_ld_act = bus.MemReadM & ~bus.MemWriteM & is_load(bus.opM);

`ifdef DMEM_MMIO_EN
    logic [31:0] r_cycle;
    logic [31:0] w_mmio_word;

    assign w_in_win   = (bus.EXResultM[31:4] == MMIO_BASE[31:4]);
    // Only aligned full-word accesses are legal in the window
    assign w_mis      = misaligned(bus.opM, w_lo) |
                        (w_in_win & ~((bus.opM == OP_LW) | (bus.opM == OP_SW)));
    assign w_stat_clr = w_st_act & w_in_win & ~w_mis & (bus.EXResultM[3:2] == MMIO_STATUS);

    always_comb begin
        case (bus.EXResultM[3:2])
            MMIO_CYCLE:  w_mmio_word = r_cycle;
            MMIO_STATUS: w_mmio_word = {r_err, 23'b0, r_fault_cnt};
            default:     w_mmio_word = 32'b0;
        endcase
    end

    assign w_raw = w_in_win ? w_mmio_word : r_mem[w_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_cycle <= 32'b0;
        else      r_cycle <= r_cycle + 32'd1;
    end
`else
    logic w_unused_bits;

    assign w_in_win      = 1'b0;
    assign w_mis         = misaligned(bus.opM, w_lo);
    assign w_stat_clr    = 1'b0;
    assign w_raw         = r_mem[w_idx];
    assign w_unused_bits = ^{bus.EXResultM[31:ADDR_W+2], r_fault_cnt};
`endif

    assign w_be     = lane_sel(bus.opM, w_lo);
    assign w_fault  = (w_ld_act | w_st_act) & w_mis;
    assign w_ram_we = w_st_act & ~w_mis & ~w_in_win;

    always_comb begin
        case (bus.opM)
            OP_SB:   w_wdata = {4{bus.WriteDataM[7:0]}};
            OP_SH:   w_wdata = {2{bus.WriteDataM[15:0]}};
            default: w_wdata = bus.WriteDataM;
        endcase
    end

    // RAM is never cleared, but sits under the reset so a store whose edge
    // lands while reset is asserted is dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
        end else if (w_ram_we) begin
            for (int b = 0; b < 4; b++)
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err       <= 1'b0;
            r_err_addr  <= 32'b0;
            r_fault_cnt <= 8'b0;
        end else if (w_fault) begin
            r_err <= 1'b1;
            if (!r_err) r_err_addr <= bus.EXResultM;
            if (r_fault_cnt != 8'hFF) r_fault_cnt <= r_fault_cnt + 8'd1;
        end else if (w_stat_clr) begin
            r_err       <= 1'b0;
            r_err_addr  <= 32'b0;
            r_fault_cnt <= 8'b0;
        end
    end

    dmem_load_align u_align (
        .i_word    (w_raw),
        .i_addr_lo (w_lo),
        .i_op      (bus.opM),
        .o_data    (w_aligned)
    );

    assign bus.ReadDataM   = (w_ld_act & ~w_mis) ? w_aligned : 32'b0;
    assign bus.DMemErr     = r_err;
    assign bus.DMemErrAddr = r_err_addr;
endmodule
